// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fetch_pkg
//  Purpose   : Shared definitions for the 6502 fetch stage. Provides the
//              sequencer state enum, the byte offsets inside the f_to_d
//              packet and the opcode size rule. Decode imports the same
//              size rule.
//  Revision  : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Sequencer states. VEC_LO/VEC_HI are only reachable when reset-vector
  // fetch is compiled in.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    OP_W   = 3'd1,
    OPR1_W = 3'd2,
    OPR2_W = 3'd3,
    HOLD   = 3'd4,
    HALT   = 3'd5,
    VEC_LO = 3'd6,
    VEC_HI = 3'd7
  } fetch_state_e;

  // Byte lanes of the 24-bit f_to_d packet.
  localparam int unsigned PKT_OPCODE_LSB = 0;
  localparam int unsigned PKT_OPR1_LSB   = 8;
  localparam int unsigned PKT_OPR2_LSB   = 16;

  // Instruction length in bytes for an opcode; 0 marks an opcode that this
  // core does not implement.
  function automatic logic [1:0] instr_size(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] sz;
    hi = op[7:4];
    lo = op[3:0];
    sz = 2'd0;
    case (lo)
      4'h0: begin
        if (hi == 4'h0 || hi == 4'h4 || hi == 4'h6) sz = 2'd1;
        else if (hi == 4'h2)                        sz = 2'd3;
        else if (hi == 4'h8)                        sz = 2'd0;
        else                                        sz = 2'd2;
      end
      4'h1, 4'h5, 4'h6: sz = 2'd2;
      4'h8:             sz = 2'd1;
      4'h9: begin
        if (hi[0])           sz = 2'd3;
        else if (hi == 4'h8) sz = 2'd0;
        else                 sz = 2'd2;
      end
      4'hA: begin
        if (!hi[0] || hi == 4'h9 || hi == 4'hB) sz = 2'd1;
        else                                    sz = 2'd0;
      end
      4'h2: sz = (hi == 4'hA) ? 2'd2 : 2'd0;
      4'h4: begin
        case (hi)
          4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE: sz = 2'd2;
          default:                                  sz = 2'd0;
        endcase
      end
      4'hC: begin
        case (hi)
          4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE: sz = 2'd3;
          default:                                        sz = 2'd0;
        endcase
      end
      4'hD: sz = 2'd3;
      4'hE: sz = (hi == 4'h9) ? 2'd0 : 2'd3;
      default: sz = 2'd0;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : fetch_sequencer_if
//  Purpose   : Bundles the fetch stage's memory read port, the f_to_d
//              handshake to decode, the execute redirect and the halt flag.
//  Ports     : master - the fetch sequencer (drives reads and packets)
//              slave  - the environment (memory, decode, execute)
//  Revision  : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [23:0] f_to_d_reg;
  logic        fd_valid;
  logic        fd_ready;
  logic [15:0] fd_pc;
  logic [1:0]  fd_size;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        illegal;

  modport master (
    output mem_rd, mem_addr, f_to_d_reg, fd_valid, fd_pc, fd_size, illegal,
    input  mem_rdata, fd_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_rd, mem_addr, f_to_d_reg, fd_valid, fd_pc, fd_size, illegal,
    output mem_rdata, fd_ready, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : fetch_sequencer
//  Purpose   : 6502 fetch-stage controller. Reads instruction bytes through
//              a byte-wide memory port with one cycle of read latency,
//              assembles 1..3 byte instructions and hands them to decode
//              through a valid/ready handshake. Handles PC sequencing,
//              execute redirects and halting on unimplemented opcodes.
//  Ports     : clk, rst - clock, synchronous active-high reset
//              bus      - fetch_sequencer_if.master (memory read port,
//                         f_to_d packet/handshake, redirect, illegal)
//  Params    : RESET_PC - PC loaded at reset
//  Macros    : RESET_VECTOR_FETCH_EN - when defined, the PC is loaded from
//              the reset vector at FFFC/FFFD before the first fetch.
//  Revision  : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [23:0]  pkt_q, pkt_d;
  logic [15:0]  fd_pc_q, fd_pc_d;
  logic [1:0]   size_q, size_d;

  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [1:0]   op_size;
  logic         vec_busy;

`ifdef RESET_VECTOR_FETCH_EN
  localparam fetch_state_e START_STATE = VEC_LO;
  localparam logic [15:0]  VEC_ADDR_LO = 16'hFFFC;
  localparam logic [15:0]  VEC_ADDR_HI = 16'hFFFD;

  // vec_pend_q separates the cycle that issues the FFFC read from the
  // cycle that receives its data, both of which sit in VEC_LO.
  logic       vec_pend_q, vec_pend_d;
  logic [7:0] vec_lo_q, vec_lo_d;

  assign vec_busy = (state_q == VEC_LO) || (state_q == VEC_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_pend_q <= 1'b0;
      vec_lo_q   <= 8'h00;
    end else begin
      vec_pend_q <= vec_pend_d;
      vec_lo_q   <= vec_lo_d;
    end
  end
`else
  localparam fetch_state_e START_STATE = FETCH;

  assign vec_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_STATE;
      pc_q    <= RESET_PC;
      pkt_q   <= 24'h0;
      fd_pc_q <= 16'h0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pkt_q   <= pkt_d;
      fd_pc_q <= fd_pc_d;
      size_q  <= size_d;
    end
  end

  assign op_size = instr_size(bus.mem_rdata);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pkt_d   = pkt_q;
    fd_pc_d = fd_pc_q;
    size_d  = size_q;
    rd_en   = 1'b0;
    rd_addr = 16'h0;
`ifdef RESET_VECTOR_FETCH_EN
    vec_pend_d = vec_pend_q;
    vec_lo_d   = vec_lo_q;
`endif

    case (state_q)
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = pc_q;
        state_d = OP_W;
      end

      OP_W: begin
        // A fresh opcode clears the operand lanes so short instructions
        // present zeros in their unused bytes.
        pkt_d   = {16'h0, bus.mem_rdata};
        fd_pc_d = pc_q;
        size_d  = op_size;
        case (op_size)
          2'd0:    state_d = HALT;
          2'd1:    state_d = HOLD;
          default: begin
            rd_en   = 1'b1;
            rd_addr = pc_q + 16'd1;
            state_d = OPR1_W;
          end
        endcase
      end

      OPR1_W: begin
        pkt_d[PKT_OPR1_LSB +: 8] = bus.mem_rdata;
        if (size_q == 2'd3) begin
          rd_en   = 1'b1;
          rd_addr = pc_q + 16'd2;
          state_d = OPR2_W;
        end else begin
          state_d = HOLD;
        end
      end

      OPR2_W: begin
        pkt_d[PKT_OPR2_LSB +: 8] = bus.mem_rdata;
        state_d = HOLD;
      end

      HOLD: begin
        if (bus.fd_ready) begin
          pc_d    = pc_q + {14'h0, size_q};
          state_d = FETCH;
        end
      end

      HALT: begin
        state_d = HALT;
      end

`ifdef RESET_VECTOR_FETCH_EN
      VEC_LO: begin
        rd_en = 1'b1;
        if (!vec_pend_q) begin
          rd_addr    = VEC_ADDR_LO;
          vec_pend_d = 1'b1;
        end else begin
          vec_lo_d   = bus.mem_rdata;
          rd_addr    = VEC_ADDR_HI;
          vec_pend_d = 1'b0;
          state_d    = VEC_HI;
        end
      end

      VEC_HI: begin
        pc_d    = {bus.mem_rdata, vec_lo_q};
        state_d = FETCH;
      end
`endif

      default: state_d = FETCH;
    endcase

    // A redirect overrides everything, including a same-cycle handshake:
    // the packet still counts as taken but the PC follows the redirect.
    // Reads that would be issued this cycle are dropped since their data
    // would only be discarded.
    if (bus.redirect_valid && !vec_busy) begin
      state_d = FETCH;
      pc_d    = bus.redirect_pc;
      rd_en   = 1'b0;
      rd_addr = 16'h0;
    end
  end

  // Strobes are masked while rst is high so nothing is read or offered
  // during the reset cycle itself.
  assign bus.mem_rd     = rd_en & ~rst;
  assign bus.mem_addr   = (rd_en & ~rst) ? rd_addr : 16'h0;
  assign bus.f_to_d_reg = pkt_q;
  assign bus.fd_pc      = fd_pc_q;
  assign bus.fd_size    = size_q;
  assign bus.fd_valid   = (state_q == HOLD) & ~rst;
  assign bus.illegal    = (state_q == HALT) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fetch_sequencer
//  Purpose   : Self-checking bench for fetch_sequencer. Provides a byte-wide
//              memory with one cycle of read latency, directed scenarios
//              and a randomized instruction stream checked against a
//              set-based opcode size reference and a transaction-level PC
//              model. Also covers RESET_VECTOR_FETCH_EN when defined.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(16'h8000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_fail   = 0;

  // Memory: data for a strobed address appears on the following cycle.
  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference size rule, written as opcode sets.
  function automatic int ref_size(input logic [7:0] op);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = op[3:0];
    hi = op[7:4];
    if (lo == 4'h8 || op inside {8'h00, 8'h40, 8'h60, 8'h0A, 8'h2A, 8'h4A,
        8'h6A, 8'h8A, 8'hAA, 8'hCA, 8'hEA, 8'h9A, 8'hBA})
      return 1;
    if (lo == 4'hD || (lo == 4'hE && op != 8'h9E) || (lo == 4'h9 && hi[0]) ||
        op inside {8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC})
      return 3;
    if (lo inside {4'h1, 4'h5, 4'h6} ||
        (lo == 4'h0 && !(op inside {8'h00, 8'h20, 8'h40, 8'h60, 8'h80})) ||
        (lo == 4'h9 && !hi[0] && op != 8'h89) ||
        op inside {8'hA2, 8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4})
      return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fd_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef RESET_VECTOR_FETCH_EN
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    repeat (3) @(posedge clk);
`endif
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fd_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.fd_valid, bus.illegal} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_strobes: got rd=%b addr=%h valid=%b illegal=%b want all 0",
               bus.mem_rd, bus.mem_addr, bus.fd_valid, bus.illegal);
    end
    n_checks++;
    if ({bus.f_to_d_reg, bus.fd_pc, bus.fd_size} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_packet: got pkt=%h pc=%h size=%0d want 0",
               bus.f_to_d_reg, bus.fd_pc, bus.fd_size);
    end
    rst = 1'b0;
    #1;
    n_checks++;
`ifdef RESET_VECTOR_FETCH_EN
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL reset_first_read: got rd=%b addr=%h want rd=1 addr=fffc",
               bus.mem_rd, bus.mem_addr);
    end
`else
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8000) begin
      n_fail++;
      $display("FAIL reset_first_read: got rd=%b addr=%h want rd=1 addr=8000",
               bus.mem_rd, bus.mem_addr);
    end
`endif
  endtask

  task automatic test_two_byte();
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05; mem[16'h8002] = 8'hEA;
    do_reset();
    bus.fd_ready = 1'b1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8000) begin
      n_fail++;
      $display("FAIL lda_opcode_read: got rd=%b addr=%h want 1/8000", bus.mem_rd, bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8001 || bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lda_operand_read: got rd=%b addr=%h valid=%b want 1/8001/0",
               bus.mem_rd, bus.mem_addr, bus.fd_valid);
    end
    tick();
    n_checks++;
    if (bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lda_early_valid: got %b want 0", bus.fd_valid);
    end
    tick();
    n_checks++;
    if ({bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size} !== {1'b1, 24'h0005A9, 16'h8000, 2'd2}) begin
      n_fail++;
      $display("FAIL lda_packet: got valid=%b pkt=%h pc=%h size=%0d want 1/0005a9/8000/2",
               bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size);
    end
    tick();
    bus.fd_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8002 || bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lda_next_fetch: got rd=%b addr=%h valid=%b want 1/8002/0",
               bus.mem_rd, bus.mem_addr, bus.fd_valid);
    end
  endtask

  task automatic test_hold();
    int n;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    do_reset();
    n = 0;
    while (bus.fd_valid !== 1'b1 && n < 10) begin tick(); n++; end
    n_checks++;
    if (bus.fd_valid !== 1'b1 || n != 4) begin
      n_fail++;
      $display("FAIL jmp_latency: got valid=%b after %0d cycles want 1 after 4", bus.fd_valid, n);
    end
    repeat (5) begin
      n_checks++;
      if (bus.fd_valid !== 1'b1 || bus.f_to_d_reg !== 24'h12344C || bus.fd_size !== 2'd3) begin
        n_fail++;
        $display("FAIL jmp_hold_stable: got valid=%b pkt=%h size=%0d want 1/12344c/3",
                 bus.fd_valid, bus.f_to_d_reg, bus.fd_size);
      end
      tick();
    end
    bus.fd_ready = 1'b1;
    tick();
    bus.fd_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8003) begin
      n_fail++;
      $display("FAIL jmp_next_fetch: got rd=%b addr=%h want 1/8003", bus.mem_rd, bus.mem_addr);
    end
  endtask

  task automatic test_halt();
    mem[16'h8000] = 8'h02;
    mem[16'h9000] = 8'hEA;
    do_reset();
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_no_operand_read: got rd=%b want 0", bus.mem_rd);
    end
    tick();
    repeat (3) begin
      n_checks++;
      if ({bus.illegal, bus.mem_rd, bus.fd_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL halt_state: got illegal=%b rd=%b valid=%b want 1/0/0",
                 bus.illegal, bus.mem_rd, bus.fd_valid);
      end
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h9000;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.illegal, bus.mem_rd} !== 2'b01 || bus.mem_addr !== 16'h9000) begin
      n_fail++;
      $display("FAIL halt_redirect: got illegal=%b rd=%b addr=%h want 0/1/9000",
               bus.illegal, bus.mem_rd, bus.mem_addr);
    end
  endtask

  task automatic test_redirect_mid();
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h01; mem[16'h8002] = 8'h02;
    mem[16'hC000] = 8'hEA;
    do_reset();
    bus.fd_ready = 1'b1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hC000;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hC000 || bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_mid_fetch: got rd=%b addr=%h valid=%b want 1/c000/0",
               bus.mem_rd, bus.mem_addr, bus.fd_valid);
    end
    tick();
    n_checks++;
    if (bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_mid_no_stale: got valid=%b want 0", bus.fd_valid);
    end
    tick();
    n_checks++;
    if ({bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size} !== {1'b1, 24'h0000EA, 16'hC000, 2'd1}) begin
      n_fail++;
      $display("FAIL redir_mid_packet: got valid=%b pkt=%h pc=%h size=%0d want 1/0000ea/c000/1",
               bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size);
    end
    bus.fd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap_opcode_read: got rd=%b addr=%h want 1/fffe", bus.mem_rd, bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_opr1_read: got rd=%b addr=%h want 1/ffff", bus.mem_rd, bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_opr2_read: got rd=%b addr=%h want 1/0000", bus.mem_rd, bus.mem_addr);
    end
    tick();
    tick();
    n_checks++;
    if ({bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size} !== {1'b1, 24'h123420, 16'hFFFE, 2'd3}) begin
      n_fail++;
      $display("FAIL wrap_packet: got valid=%b pkt=%h pc=%h size=%0d want 1/123420/fffe/3",
               bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size);
    end
    bus.fd_ready = 1'b1;
    tick();
    bus.fd_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_next_pc: got rd=%b addr=%h want 1/0001", bus.mem_rd, bus.mem_addr);
    end
  endtask

  task automatic test_redirect_handshake();
    mem[16'h8000] = 8'hEA;
    do_reset();
    tick();
    tick();
    n_checks++;
    if (bus.fd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_hs_valid: got %b want 1", bus.fd_valid);
    end
    bus.fd_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hA000;
    tick();
    bus.fd_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hA000 || bus.fd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_hs_target: got rd=%b addr=%h valid=%b want 1/a000/0",
               bus.mem_rd, bus.mem_addr, bus.fd_valid);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] pc;
    logic [7:0]  op;
    logic [23:0] exp_pkt;
    int          sz, lat, waited;
    for (int i = 0; i < 512; i++) begin
      do op = 8'($urandom); while (ref_size(op) == 0);
      mem[16'h4000 + 16'(i)] = op;
    end
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h4000;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    pc = 16'h4000;
    for (int n = 0; n < 40; n++) begin
      sz = ref_size(mem[pc]);
      exp_pkt = {(sz >= 3) ? mem[pc + 16'd2] : 8'h00,
                 (sz >= 2) ? mem[pc + 16'd1] : 8'h00, mem[pc]};
      n_checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== pc) begin
        n_fail++;
        $display("FAIL rand_fetch_addr: got rd=%b addr=%h want 1/%h", bus.mem_rd, bus.mem_addr, pc);
      end
      lat = 0;
      while (bus.fd_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
      n_checks++;
      if (lat != sz + 1) begin
        n_fail++;
        $display("FAIL rand_latency: got %0d cycles want %0d (pc=%h)", lat, sz + 1, pc);
      end
      waited = 0;
      forever begin
        bus.fd_ready = ($urandom_range(0, 2) != 0) || (waited > 6);
        #1;
        n_checks++;
        if ({bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size} !== {1'b1, exp_pkt, pc, 2'(sz)}) begin
          n_fail++;
          $display("FAIL rand_packet: got valid=%b pkt=%h pc=%h size=%0d want 1/%h/%h/%0d",
                   bus.fd_valid, bus.f_to_d_reg, bus.fd_pc, bus.fd_size, exp_pkt, pc, sz);
        end
        if (bus.fd_ready) break;
        tick();
        waited++;
      end
      tick();
      bus.fd_ready = 1'b0;
      #1;
      pc = pc + 16'(sz);
    end
  endtask

`ifdef RESET_VECTOR_FETCH_EN
  task automatic test_vector();
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hE0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL vec_lo_read: got rd=%b addr=%h want 1/fffc", bus.mem_rd, bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFD) begin
      n_fail++;
      $display("FAIL vec_hi_read: got rd=%b addr=%h want 1/fffd", bus.mem_rd, bus.mem_addr);
    end
    tick();
    tick();
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hE000) begin
      n_fail++;
      $display("FAIL vec_first_fetch: got rd=%b addr=%h want 1/e000", bus.mem_rd, bus.mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL vec_restart: got rd=%b addr=%h want 1/fffc", bus.mem_rd, bus.mem_addr);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.fd_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0;
    test_reset();
    test_two_byte();
    test_hold();
    test_halt();
    test_redirect_mid();
    test_wrap();
    test_redirect_handshake();
    test_random_stream();
`ifdef RESET_VECTOR_FETCH_EN
    test_vector();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage controller for the 6502 pipeline.
- Reads instruction bytes through a byte-wide, 1-cycle-latency memory read port.
- Assembles 1–3 byte instructions using the opcode size rule and presents them to decode as a 24-bit f_to_d packet with a valid/ready handshake.
- Handles PC sequencing, execute-stage redirects, and halting on unimplemented opcodes.

Parameters:
RESET_PC, 16'h8000, PC loaded at reset when vector fetch is compiled out

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_rd  out  1  read strobe; mem_rdata is valid on the cycle after the strobe
mem_addr  out  16  read address
mem_rdata  in  8  read data
f_to_d_reg  out  24  packet: [7:0] opcode, [15:8] operand byte 1, [23:16] operand byte 2; unused bytes 0
fd_valid  out  1  packet valid
fd_ready  in  1  decode accepts the packet
fd_pc  out  16  address of the packet's opcode
fd_size  out  2  instruction size 1..3
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  16  new PC
illegal  out  1  high while halted on an unimplemented opcode

Behaviour:
- Reset values: all outputs 0; PC = RESET_PC; state FETCH (or VEC_LO with the optional feature).
- Size rule (low nibble L, high nibble H; size 0 = unimplemented):
  - L=0: 00/40/60→1; 20→3; 80→0; all other H→2.
  - L=1, L=5, L=6: 2.
  - L=8: 1.
  - L=9: even H→2, except 89→0; odd H→3.
  - L=A: even H→1; 9A, BA→1; other odd H→0.
  - L=2: A2→2; otherwise 0.
  - L=4: 24/84/94/A4/B4/C4/E4→2; otherwise 0.
  - L=C: H in {2,4,6,8,A,B,C,E}→3; otherwise 0.
  - L=D: 3.
  - L=E: 3, except 9E→0.
  - L=3, L=7, L=B, L=F: 0.
- FSM states: FETCH, OP_W, OPR1_W, OPR2_W, HOLD, HALT.
  - FETCH: mem_rd=1, mem_addr=PC → OP_W.
  - OP_W: capture opcode.
    - size 0 → HALT.
    - size 1 → HOLD.
    - size ≥2: issue read at PC+1 → OPR1_W.
  - OPR1_W: capture byte 1.
    - size 3: issue read at PC+2 → OPR2_W.
    - otherwise → HOLD.
  - OPR2_W: capture byte 2 → HOLD.
  - HOLD: fd_valid=1; packet, fd_pc and fd_size stable.
    - On fd_valid&fd_ready: PC += size → FETCH.
  - HALT: illegal=1, fd_valid=0, no reads. Exit only by redirect or rst.
- Latency from FETCH to fd_valid: 2/3/4 cycles for size 1/2/3. One bubble cycle follows each handshake.
- PC arithmetic is mod 2^16; operand addresses wrap FFFF→0000.
- redirect_valid (any state, including HALT):
  - PC ← redirect_pc; illegal ← 0; state → FETCH next cycle.
  - In-flight read data is discarded.
  - fd_valid drops the next cycle.
  - Redirect in the same cycle as a handshake: the packet counts as transferred; PC takes redirect_pc, not PC+size.
- rst mid-operation: immediate return to reset values. No packet is emitted and any pending read is ignored.
- fd_valid never falls without a handshake, except on redirect or rst.

Optional Feature:
- Macro RESET_VECTOR_FETCH_EN.
- Defined: after reset, states VEC_LO and VEC_HI run first.
  - Read FFFC, then FFFD; PC ← {hi, lo} → FETCH.
  - First opcode read happens 3 cycles after reset deasserts.
  - redirect_valid is ignored during VEC states.
- Undefined: PC ← RESET_PC; first read happens in the first cycle after reset.

Decomposition:
- Shared package fetch_pkg:
  - state enum;
  - packet byte-offset constants;
  - function instr_size(opcode) → 2 bits, implementing the rule above. Also reused by decode.
- No sub-module. FSM, PC and packet registers all live in one module.

Test Plan:
1. Reset, PC=8000, memory A9 05 → mem_addr 8000 then 8001; f_to_d_reg=0x0005A9, fd_size=2, fd_pc=8000, fd_valid on the 3rd cycle after FETCH; next fetch at 8002.
2. Memory 4C 34 12 at 8000, fd_ready held low for 5 cycles → packet 0x12344C held stable; after the handshake, next read at 8003.
3. Opcode 02 → HALT, illegal=1, mem_rd stays 0; redirect_pc=9000 → illegal=0, next read at 9000.
4. Redirect to C000 while in OPR1_W → operand discarded, no fd_valid; next mem_addr=C000.
5. 3-byte opcode 20 at FFFE → operand reads at FFFF and 0000; after the handshake PC=0001.
6. With RESET_VECTOR_FETCH_EN and FFFC=00, FFFD=E0 → reads FFFC, FFFD, then E000; with rst pulsed in VEC_HI, the sequence restarts from FFFC.
